// File: rtl/stepper_sequencer_pkg.sv
// Shared definitions for the stepper sequencer: coil-mode encodings and the
// sequencer FSM state type.
package stepper_sequencer_pkg;

   localparam logic [1:0] MODE_WAVE = 2'b00;
   localparam logic [1:0] MODE_FULL = 2'b01;
   localparam logic [1:0] MODE_HALF = 2'b10;
   localparam logic [1:0] MODE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/stepper_sequencer_phase_pattern.sv
// Combinational coil pattern for a phase index (0..2*PHASES-1) and a drive mode.
// The reserved mode yields no coils; it never steps, so the held pattern is kept.
module stepper_phase_pattern #(
   parameter int unsigned PHASES = 4,
   parameter int unsigned IDX_W  = $clog2(2 * PHASES)
) (
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [1:0]        i_mode,
   output logic [PHASES-1:0] o_pattern
);
   import stepper_sequencer_pkg::*;

   logic [IDX_W-1:0]  w_a;
   logic [IDX_W-1:0]  w_b;
   logic [PHASES-1:0] w_bit_a;
   logic [PHASES-1:0] w_bit_b;

   // Odd half-step indices energise the same coil pair as full mode at idx>>1.
   always_comb begin
      w_a       = i_idx >> 1;
      w_b       = (w_a == IDX_W'(PHASES - 1)) ? '0 : w_a + IDX_W'(1);
      w_bit_a   = PHASES'(1) << w_a;
      w_bit_b   = PHASES'(1) << w_b;
      o_pattern = '0;
      case (i_mode)
         MODE_WAVE: o_pattern = w_bit_a;
         MODE_FULL: o_pattern = w_bit_a | w_bit_b;
         MODE_HALF: o_pattern = i_idx[0] ? (w_bit_a | w_bit_b) : w_bit_a;
         default:   o_pattern = '0;
      endcase
   end

endmodule

// File: rtl/stepper_sequencer.sv
// Stepper motor move sequencer: accepts a move command, issues timed steps,
// tracks a signed position and drives registered coil patterns.
module stepper_sequencer #(
   parameter int unsigned PHASES = 4,
   parameter int unsigned DIV_W  = 16,
   parameter int unsigned STEP_W = 16,
   parameter int unsigned POS_W  = 32
) (
   input  logic              system1000,
   input  logic              system1000_rstn,
   input  logic              en,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [1:0]        cmd_mode,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic [DIV_W-1:0]  cmd_period,
   input  logic              abort,
   output logic [PHASES-1:0] coils,
   output logic [POS_W-1:0]  position,
   output logic              busy,
   output logic              done
);
   import stepper_sequencer_pkg::*;

   localparam int unsigned NIDX  = 2 * PHASES;
   localparam int unsigned IDX_W = $clog2(NIDX);

   state_t            r_state;
   state_t            w_state_next;
   logic              r_dir;
   logic [1:0]        r_mode;
   logic [STEP_W-1:0] r_remaining;
   logic [DIV_W-1:0]  r_period;
   logic [DIV_W-1:0]  r_div;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  w_idx_next;
   logic [IDX_W:0]    w_stride;
   logic [IDX_W:0]    w_wide;
   logic [POS_W-1:0]  r_pos;
   logic [PHASES-1:0] r_pat;
   logic [PHASES-1:0] r_coils;
   logic [PHASES-1:0] w_pattern;
   logic [PHASES-1:0] w_pat_hold;
   logic              w_accept;
   logic              w_zero_move;
   logic              w_tick;
   logic              w_last;

   assign w_accept    = cmd_valid && (r_state == ST_IDLE);
   assign w_zero_move = (cmd_steps == '0) || (cmd_mode == MODE_RSVD);
   assign w_tick      = (r_state == ST_RUN) && !abort && (r_div == r_period - DIV_W'(1));
   assign w_last      = (r_remaining == STEP_W'(1));

   always_comb begin
      w_state_next = r_state;
      cmd_ready    = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (w_accept) w_state_next = w_zero_move ? ST_FIN : ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (abort || (w_tick && w_last)) w_state_next = ST_FIN;
         end
         ST_FIN: begin
            done         = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Modulo-2*PHASES stepping done one bit wider so non-power-of-two rings wrap.
   always_comb begin
      w_stride = (r_mode == MODE_HALF) ? (IDX_W+1)'(1) : (IDX_W+1)'(2);
      if (r_dir) w_wide = {1'b0, r_idx} + w_stride;
      else       w_wide = {1'b0, r_idx} + (IDX_W+1)'(NIDX) - w_stride;
      if (w_wide >= (IDX_W+1)'(NIDX)) w_wide = w_wide - (IDX_W+1)'(NIDX);
      w_idx_next = w_wide[IDX_W-1:0];
   end

   stepper_phase_pattern #(
      .PHASES (PHASES),
      .IDX_W  (IDX_W)
   ) u_pattern (
      .i_idx     (w_idx_next),
      .i_mode    (r_mode),
      .o_pattern (w_pattern)
   );

   assign w_pat_hold = w_tick ? w_pattern : r_pat;

   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) r_state <= ST_IDLE;
      else                  r_state <= w_state_next;
   end

   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         r_dir       <= 1'b0;
         r_mode      <= MODE_WAVE;
         r_remaining <= '0;
         r_period    <= DIV_W'(1);
         r_div       <= '0;
         r_idx       <= '0;
         r_pos       <= '0;
         r_pat       <= '0;
         r_coils     <= '0;
      end else begin
         r_pat   <= w_pat_hold;
         r_coils <= en ? w_pat_hold : '0;
         if (w_accept) begin
            r_dir       <= cmd_dir;
            r_mode      <= cmd_mode;
            r_remaining <= cmd_steps;
            r_period    <= (cmd_period == '0) ? DIV_W'(1) : cmd_period;
            r_div       <= '0;
         end else if (w_tick) begin
            r_div       <= '0;
            r_remaining <= r_remaining - STEP_W'(1);
            r_idx       <= w_idx_next;
            r_pos       <= r_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
         end else if (r_state == ST_RUN) begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

   assign coils    = r_coils;
   assign position = r_pos;

endmodule

// File: tb/tb_stepper_sequencer.sv
// Directed bench for stepper_sequencer (PHASES=4) with hand-computed coil,
// position and handshake expectations.
module tb_stepper_sequencer;
   import stepper_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        en;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_dir;
   logic [1:0]  cmd_mode;
   logic [15:0] cmd_steps;
   logic [15:0] cmd_period;
   logic        abort;
   logic [3:0]  coils;
   logic [31:0] position;
   logic        busy;
   logic        done;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stepper_sequencer #(
      .PHASES (4),
      .DIV_W  (16),
      .STEP_W (16),
      .POS_W  (32)
   ) dut (
      .system1000      (clk),
      .system1000_rstn (rstn),
      .en              (en),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_dir         (cmd_dir),
      .cmd_mode        (cmd_mode),
      .cmd_steps       (cmd_steps),
      .cmd_period      (cmd_period),
      .abort           (abort),
      .coils           (coils),
      .position        (position),
      .busy            (busy),
      .done            (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic status(input string tag, input logic [3:0] e_coils, input logic [31:0] e_pos,
                         input logic e_busy, input logic e_done);
      chk({tag, ".coils"}, 32'(coils), 32'(e_coils));
      chk({tag, ".pos"},   position, e_pos);
      chk({tag, ".busy"},  32'(busy), 32'(e_busy));
      chk({tag, ".done"},  32'(done), 32'(e_done));
      chk({tag, ".ready"}, 32'(cmd_ready), 32'(!(e_busy || e_done)));
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one command for a single accepting edge, then scrambles the bus.
   task automatic start(input logic d, input logic [1:0] m, input logic [15:0] s,
                        input logic [15:0] p);
      cmd_dir    = d;
      cmd_mode   = m;
      cmd_steps  = s;
      cmd_period = p;
      cmd_valid  = 1'b1;
      chk("accept.ready", 32'(cmd_ready), 32'h1);
      cyc(1);
      cmd_valid  = 1'b0;
      cmd_dir    = ~d;
      cmd_mode   = ~m;
      cmd_steps  = 16'hFFFF;
      cmd_period = 16'h0005;
   endtask

   logic [3:0] full_seq [4];

   initial begin
      full_seq   = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
      rstn       = 1'b0;
      en         = 1'b1;
      cmd_valid  = 1'b0;
      cmd_dir    = 1'b0;
      cmd_mode   = MODE_WAVE;
      cmd_steps  = '0;
      cmd_period = '0;
      abort      = 1'b0;

      #7;
      status("reset", 4'b0000, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      cyc(1);
      status("post_reset", 4'b0000, 32'h0, 1'b0, 1'b0);

      abort = 1'b1;
      cyc(1);
      status("idle_abort", 4'b0000, 32'h0, 1'b0, 1'b0);
      abort = 1'b0;

      // half, reverse, 3 steps, period 1 from idx 0
      start(1'b0, MODE_HALF, 16'd3, 16'd1);
      status("half_rev.acc", 4'b0000, 32'h0, 1'b1, 1'b0);
      cyc(1); status("half_rev.s1", 4'b1001, 32'hFFFF_FFFF, 1'b1, 1'b0);
      cyc(1); status("half_rev.s2", 4'b1000, 32'hFFFF_FFFE, 1'b1, 1'b0);
      cyc(1); status("half_rev.s3", 4'b1100, 32'hFFFF_FFFD, 1'b0, 1'b1);
      cyc(1); status("half_rev.end", 4'b1100, 32'hFFFF_FFFD, 1'b0, 1'b0);

      // one half step forward: idx 5 -> 6
      start(1'b1, MODE_HALF, 16'd1, 16'd1);
      status("half_fwd.acc", 4'b1100, 32'hFFFF_FFFD, 1'b1, 1'b0);
      cyc(1); status("half_fwd.s1", 4'b1000, 32'hFFFF_FFFE, 1'b0, 1'b1);
      cyc(1); status("half_fwd.end", 4'b1000, 32'hFFFF_FFFE, 1'b0, 1'b0);

      // full, forward, 4 steps, period 3 from idx 6
      start(1'b1, MODE_FULL, 16'd4, 16'd3);
      cyc(2); status("full.pre", 4'b1000, 32'hFFFF_FFFE, 1'b1, 1'b0);
      cyc(1); status("full.s1", full_seq[0], 32'hFFFF_FFFF, 1'b1, 1'b0);
      for (int k = 1; k < 4; k++) begin
         cyc(3);
         status("full.sN", full_seq[k], 32'(k - 1), (k != 3), (k == 3));
      end
      cyc(1); status("full.end", 4'b1001, 32'd2, 1'b0, 1'b0);

      // wave, 5 steps, period 2, abort after two steps
      start(1'b1, MODE_WAVE, 16'd5, 16'd2);
      cyc(2); status("wave_ab.s1", 4'b0001, 32'd3, 1'b1, 1'b0);
      cyc(2); status("wave_ab.s2", 4'b0010, 32'd4, 1'b1, 1'b0);
      abort = 1'b1;
      cyc(1); status("wave_ab.fin", 4'b0010, 32'd4, 1'b0, 1'b1);
      abort = 1'b0;
      cyc(1); status("wave_ab.end", 4'b0010, 32'd4, 1'b0, 1'b0);
      cyc(3); status("wave_ab.hold", 4'b0010, 32'd4, 1'b0, 1'b0);

      // abort coinciding with a due tick: the step is not taken
      start(1'b1, MODE_WAVE, 16'd5, 16'd2);
      cyc(2); status("collide.s1", 4'b0100, 32'd5, 1'b1, 1'b0);
      cyc(1); status("collide.due", 4'b0100, 32'd5, 1'b1, 1'b0);
      abort = 1'b1;
      cyc(1); status("collide.fin", 4'b0100, 32'd5, 1'b0, 1'b1);
      abort = 1'b0;
      cyc(1);

      // zero-step and reserved-mode moves
      start(1'b1, MODE_FULL, 16'd0, 16'd3);
      status("zero.fin", 4'b0100, 32'd5, 1'b0, 1'b1);
      cyc(1); status("zero.end", 4'b0100, 32'd5, 1'b0, 1'b0);
      start(1'b0, MODE_RSVD, 16'd5, 16'd1);
      status("rsvd.fin", 4'b0100, 32'd5, 1'b0, 1'b1);
      cyc(2); status("rsvd.end", 4'b0100, 32'd5, 1'b0, 1'b0);

      // period 0 steps every cycle; en low blanks coils but not motion
      en = 1'b0;
      cyc(1); status("en_off.idle", 4'b0000, 32'd5, 1'b0, 1'b0);
      start(1'b1, MODE_WAVE, 16'd3, 16'd0);
      status("p0.acc", 4'b0000, 32'd5, 1'b1, 1'b0);
      cyc(1); status("p0.s1", 4'b0000, 32'd6, 1'b1, 1'b0);
      cyc(1); status("p0.s2", 4'b0000, 32'd7, 1'b1, 1'b0);
      cyc(1); status("p0.s3", 4'b0000, 32'd8, 1'b0, 1'b1);
      cyc(1);
      en = 1'b1;
      cyc(1); status("en_on.hold", 4'b0010, 32'd8, 1'b0, 1'b0);

      // reset in the middle of a move
      start(1'b1, MODE_FULL, 16'd10, 16'd2);
      cyc(2); status("rst_mid.s1", 4'b1100, 32'd9, 1'b1, 1'b0);
      #2 rstn = 1'b0;
      #1 status("rst_mid.async", 4'b0000, 32'd0, 1'b0, 1'b0);
      cyc(2); status("rst_mid.held", 4'b0000, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      cyc(1); status("rst_mid.release", 4'b0000, 32'd0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stepper_sequencer.md
STEPPER_SEQUENCER -- requirements
Module: stepper_sequencer

Interface
REQ-001 Parameter PHASES, default 4, number of motor coils (2..8).
REQ-002 Parameter DIV_W, default 16, width of step-period divider.
REQ-003 Parameter STEP_W, default 16, width of move-length field.
REQ-004 Parameter POS_W, default 32, width of signed position counter.
REQ-005 system1000  in  1  sole clock, rising edge.
REQ-006 system1000_rstn  in  1  reset, asynchronous, active-low.
REQ-007 en  in  1  coil enable; 0 forces coils to all-zero.
REQ-008 cmd_valid  in  1  move request.
REQ-009 cmd_ready  out  1  high only in IDLE.
REQ-010 cmd_dir  in  1  1 = forward (+), 0 = reverse (-).
REQ-011 cmd_mode  in  2  00 wave, 01 full, 10 half, 11 reserved.
REQ-012 cmd_steps  in  STEP_W  number of steps to issue.
REQ-013 cmd_period  in  DIV_W  clock cycles per step.
REQ-014 abort  in  1  terminate current move.
REQ-015 coils  out  PHASES  registered coil drive.
REQ-016 position  out  POS_W  signed step count, two's-complement.
REQ-017 busy  out  1  high in RUN.
REQ-018 done  out  1  one-cycle pulse at move end.

Function
REQ-019 FSM states IDLE, RUN, FIN; IDLE->RUN on cmd_valid&&cmd_ready with cmd_steps>0; IDLE->FIN on accept with cmd_steps=0; RUN->FIN when remaining reaches 0 or abort=1; FIN->IDLE unconditionally.
REQ-020 On accept, dir, mode, steps and period are latched; later changes to cmd_* have no effect until next accept.
REQ-021 Mode 11 is accepted and treated as zero-step move (FIN next cycle, no motion).
REQ-022 Effective period = max(cmd_period,1); divider counts 0..period-1 in RUN and issues a step tick on period-1, so first step occurs period cycles after accept and steps repeat every period cycles.
REQ-023 Internal phase index idx ranges 0..2*PHASES-1, wraps modulo 2*PHASES in both directions.
REQ-024 Per tick, idx changes by +-1 in half mode and +-2 in wave/full mode; position changes by +-1 every tick regardless of mode, wrapping modulo 2^POS_W.
REQ-025 Pattern: wave = one-hot bit (idx>>1); full = bits (idx>>1) and ((idx>>1)+1) mod PHASES; half = one-hot bit idx/2 for even idx, bits (idx-1)/2 and (idx+1)/2 mod PHASES for odd idx.
REQ-026 coils = en ? pattern(idx, latched mode) : 0, registered, updating the cycle after the tick.
REQ-027 In IDLE/FIN coils hold the last pattern (holding torque) subject to en.
REQ-028 abort in RUN: no further tick issued from that cycle, FIN next cycle; abort in IDLE/FIN ignored.
REQ-029 Tick and abort in the same cycle: abort wins, step not taken.
REQ-030 done=1 exactly in FIN; busy=1 exactly in RUN; cmd_ready=1 exactly in IDLE.
REQ-031 en low during RUN does not pause stepping; idx and position keep advancing.

Reset
REQ-032 On reset assertion, asynchronously: state=IDLE, idx=0, divider=0, remaining=0, position=0, coils=0, busy=0, done=0.
REQ-033 Reset mid-move abandons the move without a done pulse; cmd_ready=1 first cycle after release.

Structure
REQ-034 Shared package holds mode encoding constants and FSM state typedef.
REQ-035 Pattern generation (idx, mode -> coils) is a combinational sub-module stepper_phase_pattern.

Verification
REQ-036 PHASES=4, full, fwd, steps=4, period=3 -> coils 0011,0110,1100,1001 at cycles 3,6,9,12 (+1 register), position=4, done one cycle.
REQ-037 Half, rev, steps=3, period=1 from idx=0 -> coils 1001,1000,1100; position=-3.
REQ-038 Wave, steps=5, period=2, abort at cycle 5 -> exactly 2 steps, done at cycle 6, position=2.
REQ-039 steps=0 and mode=11 -> done one cycle after accept, coils and position unchanged.
REQ-040 period=0 -> step every cycle; en=0 throughout -> coils=0 but position advances to steps.
REQ-041 Reset asserted mid-RUN -> coils=0, position=0 immediately, no done pulse.
